// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 keyboard front end: deserializes frames, tracks make/break/extended
// prefixes and translates letter, digit and space make codes to 7-bit ASCII.
module ps2_ascii_decoder #(
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [6:0] ascii,
    output logic       ascii_valid,
    output logic       frame_err
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } state_t;

    logic           clk_s1, clk_s2, clk_s3;
    logic           data_s1, data_s2;
    logic           fall;
    logic [3:0]     bit_cnt;
    logic [7:0]     shift;
    logic           parity;
    logic [WDW-1:0] watchdog;
    logic           byte_ready;
    logic [7:0]     rx_byte;
    state_t         state;
    logic           map_hit;
    logic [6:0]     map_char;

    // Two-flop synchronizers plus one extra clock stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fall = clk_s3 & ~clk_s2;

    // Frame deserializer with watchdog; an edge in the expiry cycle takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            parity     <= 1'b0;
            watchdog   <= '0;
            byte_ready <= 1'b0;
            rx_byte    <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            byte_ready <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                watchdog <= '0;
                if (bit_cnt == 4'd0) begin
                    if (data_s2) begin
                        frame_err <= 1'b1;
                    end else begin
                        bit_cnt <= 4'd1;
                    end
                end else if (bit_cnt <= 4'd8) begin
                    shift   <= {data_s2, shift[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    parity  <= data_s2;
                    bit_cnt <= 4'd10;
                end else begin
                    bit_cnt <= 4'd0;
                    if ((^{shift, parity}) && data_s2) begin
                        byte_ready <= 1'b1;
                        rx_byte    <= shift;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (bit_cnt != 4'd0) begin
                if (watchdog == WD_LAST) begin
                    watchdog  <= '0;
                    bit_cnt   <= 4'd0;
                    frame_err <= 1'b1;
                end else begin
                    watchdog <= watchdog + 1'b1;
                end
            end else begin
                watchdog <= '0;
            end
        end
    end

    // Set-2 make code to uppercase ASCII lookup.
    always_comb begin
        map_hit  = 1'b1;
        map_char = 7'h00;
        case (rx_byte)
            8'h1C: map_char = 7'h41;
            8'h32: map_char = 7'h42;
            8'h21: map_char = 7'h43;
            8'h23: map_char = 7'h44;
            8'h24: map_char = 7'h45;
            8'h2B: map_char = 7'h46;
            8'h34: map_char = 7'h47;
            8'h33: map_char = 7'h48;
            8'h43: map_char = 7'h49;
            8'h3B: map_char = 7'h4A;
            8'h42: map_char = 7'h4B;
            8'h4B: map_char = 7'h4C;
            8'h3A: map_char = 7'h4D;
            8'h31: map_char = 7'h4E;
            8'h44: map_char = 7'h4F;
            8'h4D: map_char = 7'h50;
            8'h15: map_char = 7'h51;
            8'h2D: map_char = 7'h52;
            8'h1B: map_char = 7'h53;
            8'h2C: map_char = 7'h54;
            8'h3C: map_char = 7'h55;
            8'h2A: map_char = 7'h56;
            8'h1D: map_char = 7'h57;
            8'h22: map_char = 7'h58;
            8'h35: map_char = 7'h59;
            8'h1A: map_char = 7'h5A;
            8'h45: map_char = 7'h30;
            8'h16: map_char = 7'h31;
            8'h1E: map_char = 7'h32;
            8'h26: map_char = 7'h33;
            8'h25: map_char = 7'h34;
            8'h2E: map_char = 7'h35;
            8'h36: map_char = 7'h36;
            8'h3D: map_char = 7'h37;
            8'h3E: map_char = 7'h38;
            8'h46: map_char = 7'h39;
            8'h29: map_char = 7'h20;
            default: map_hit = 1'b0;
        endcase
    end

    // Prefix-tracking decode FSM; advances only on good bytes, so frame errors never touch it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ascii       <= 7'h00;
            ascii_valid <= 1'b0;
        end else begin
            ascii_valid <= 1'b0;
            if (byte_ready) begin
                case (state)
                    IDLE: begin
                        if (rx_byte == 8'hF0) begin
                            state <= BREAK;
                        end else if (rx_byte == 8'hE0) begin
                            state <= EXT;
                        end else if (map_hit) begin
                            ascii       <= map_char;
                            ascii_valid <= 1'b1;
                        end
                    end
                    EXT: begin
                        state <= (rx_byte == 8'hF0) ? EXT_BREAK : IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder: bit-bangs PS/2 frames and checks decoded
// characters, pulse counts, latency and error handling against hand-computed values.
module tb_ps2_ascii_decoder;

    localparam int TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [6:0] ascii;
    logic       ascii_valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int validCount = 0;
    int errCount = 0;
    int bothCount = 0;
    int lastValidCyc = 0;
    int lastFallCyc = 0;
    int v0, e0;

    ps2_ascii_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .ascii(ascii),
        .ascii_valid(ascii_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled half a cycle away from the active edge.
    always @(negedge clk) begin
        if (ascii_valid) begin
            validCount   <= validCount + 1;
            lastValidCyc <= cyc;
        end
        if (frame_err) errCount <= errCount + 1;
        if (ascii_valid && frame_err) bothCount <= bothCount + 1;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic ps2Bit(input logic v);
        ps2_data = v;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        lastFallCyc = cyc;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Sends the first nBits bits of a frame for byte b (odd parity unless badParity).
    task automatic applyStimulus(input logic [7:0] b, input bit badParity, input int nBits);
        logic [10:0] frame;
        logic        p;
        p = ~(^b) ^ badParity;
        frame = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nBits; i++) ps2Bit(frame[i]);
        ps2_data = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic snap;
        v0 = validCount;
        e0 = errCount;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset ascii", int'(ascii), 0);
        checkOutput("reset valid", int'(ascii_valid), 0);
        checkOutput("reset err", int'(frame_err), 0);

        // Single make code with latency check.
        snap();
        applyStimulus(8'h1C, 1'b0, 11);
        checkOutput("t1 ascii", int'(ascii), 'h41);
        checkOutput("t1 valid count", validCount - v0, 1);
        checkOutput("t1 latency", lastValidCyc - lastFallCyc, 4);
        checkOutput("t1 err count", errCount - e0, 0);

        // Make/break sequence.
        snap();
        applyStimulus(8'h1C, 1'b0, 11);
        applyStimulus(8'hF0, 1'b0, 11);
        applyStimulus(8'h1C, 1'b0, 11);
        checkOutput("t2 valid count", validCount - v0, 1);
        checkOutput("t2 ascii", int'(ascii), 'h41);

        // Bad parity then good digit.
        snap();
        applyStimulus(8'h1A, 1'b1, 11);
        checkOutput("t3 err count", errCount - e0, 1);
        checkOutput("t3 no valid", validCount - v0, 0);
        checkOutput("t3 ascii held", int'(ascii), 'h41);
        applyStimulus(8'h45, 1'b0, 11);
        checkOutput("t3 ascii digit", int'(ascii), 'h30);

        // Partial frame then timeout.
        snap();
        applyStimulus(8'h55, 1'b0, 5);
        repeat (TIMEOUT + 50) @(negedge clk);
        checkOutput("t4 timeout err", errCount - e0, 1);
        checkOutput("t4 no valid", validCount - v0, 0);
        applyStimulus(8'h29, 1'b0, 11);
        checkOutput("t4 space", int'(ascii), 'h20);

        // Extended make and extended break sequences.
        snap();
        applyStimulus(8'hE0, 1'b0, 11);
        applyStimulus(8'h1C, 1'b0, 11);
        applyStimulus(8'hE0, 1'b0, 11);
        applyStimulus(8'hF0, 1'b0, 11);
        applyStimulus(8'h1C, 1'b0, 11);
        checkOutput("t5 no valid", validCount - v0, 0);
        checkOutput("t5 ascii held", int'(ascii), 'h20);
        applyStimulus(8'h16, 1'b0, 11);
        checkOutput("t5 ascii one", int'(ascii), 'h31);
        checkOutput("t5 valid count", validCount - v0, 1);

        // Unmapped code, typematic repeat, start-bit error.
        snap();
        applyStimulus(8'h76, 1'b0, 11);
        checkOutput("unmapped no valid", validCount - v0, 0);
        applyStimulus(8'h46, 1'b0, 11);
        applyStimulus(8'h46, 1'b0, 11);
        checkOutput("typematic count", validCount - v0, 2);
        checkOutput("typematic ascii", int'(ascii), 'h39);
        snap();
        ps2Bit(1'b1);
        repeat (4) @(negedge clk);
        checkOutput("start bit err", errCount - e0, 1);
        applyStimulus(8'h16, 1'b0, 11);
        checkOutput("after start err", int'(ascii), 'h31);

        // Reset in the middle of a frame.
        snap();
        applyStimulus(8'h32, 1'b0, 5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("t6 ascii reset", int'(ascii), 0);
        checkOutput("t6 no valid", validCount - v0, 0);
        checkOutput("t6 no err", errCount - e0, 0);
        applyStimulus(8'h32, 1'b0, 11);
        checkOutput("t6 ascii B", int'(ascii), 'h42);
        checkOutput("t6 valid count", validCount - v0, 1);

        checkOutput("never both", bothCount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
